// File: rtl/shader_ray_intake.sv
// Ray intake stage between the primary ray generator and the shader: a
// first-word-fall-through FIFO with pixelID sequence checking and frame tracking.

`ifndef NUM_RAYS_DEFAULT
`define NUM_RAYS_DEFAULT 6
`endif

package shader_ray_pkg;
  typedef logic [15:0] pixelID_t;
  typedef struct packed {
    logic [31:0] origin;
    logic [31:0] dir;
    pixelID_t    pixelID;
  } prg_ray_t;
endpackage

module shader_ray_intake
  import shader_ray_pkg::*;
#(
  parameter int NUM_RAYS = `NUM_RAYS_DEFAULT,
  parameter int DEPTH    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         prg_to_shader_valid,
  input  logic [$bits(prg_ray_t)-1:0]  prg_to_shader_data,
  output logic                         prg_to_shader_stall,
  output logic                         ray_valid,
  output logic [$bits(prg_ray_t)-1:0]  ray_data,
  input  logic                         ray_stall,
  output logic                         frame_done,
  output logic [7:0]                   frame_count,
  output logic                         seq_error,
  output logic [$bits(pixelID_t)-1:0]  err_pixelID,
  input  logic                         clear_error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam pixelID_t LAST_ID = pixelID_t'(NUM_RAYS - 1);

  typedef enum logic {IDLE = 1'b0, INFRAME = 1'b1} state_t;

  prg_ray_t   mem_q [DEPTH];
  prg_ray_t   in_ray;
  logic       push;
  logic       pop;
  logic       is_last;
  logic       mismatch;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             valid_q, valid_d;
  logic             frame_done_q, frame_done_d;
  logic [7:0]       frame_count_q, frame_count_d;
  logic             seq_error_q, seq_error_d;
  pixelID_t         err_id_q, err_id_d;
  pixelID_t         expected_id_q, expected_id_d;
  state_t           state_q, state_d;

  assign in_ray   = prg_to_shader_data;
  assign is_last  = (in_ray.pixelID == LAST_ID);
  assign mismatch = push && (in_ray.pixelID != expected_id_q);

  always_comb begin
    push          = prg_to_shader_valid && !full_q;
    pop           = valid_q && !ray_stall;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    seq_error_d   = seq_error_q;
    err_id_d      = err_id_q;
    expected_id_d = expected_id_q;
    state_d       = state_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
    full_d  = (count_d == CNT_W'(DEPTH));
    valid_d = (count_d != CNT_W'(0));

    // A mismatch in the same cycle as clear_error takes priority over the clear.
    if (mismatch && (!seq_error_q || clear_error)) begin
      seq_error_d = 1'b1;
      err_id_d    = in_ray.pixelID;
    end else if (clear_error) begin
      seq_error_d = 1'b0;
      err_id_d    = '0;
    end else begin
      seq_error_d = seq_error_q;
      err_id_d    = err_id_q;
    end

    if (push) begin
      expected_id_d = is_last ? pixelID_t'(0) : in_ray.pixelID + pixelID_t'(1);
    end else begin
      expected_id_d = expected_id_q;
    end

    if (push && is_last) begin
      frame_done_d  = 1'b1;
      frame_count_d = frame_count_q + 8'd1;
    end else begin
      frame_done_d  = 1'b0;
      frame_count_d = frame_count_q;
    end

    case (state_q)
      IDLE: begin
        if (push && !is_last) begin
          state_d = INFRAME;
        end else begin
          state_d = IDLE;
        end
      end
      INFRAME: begin
        if (push && is_last) begin
          state_d = IDLE;
        end else begin
          state_d = INFRAME;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      full_q        <= 1'b0;
      valid_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 8'd0;
      seq_error_q   <= 1'b0;
      err_id_q      <= '0;
      expected_id_q <= '0;
      state_q       <= IDLE;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      full_q        <= full_d;
      valid_q       <= valid_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      seq_error_q   <= seq_error_d;
      err_id_q      <= err_id_d;
      expected_id_q <= expected_id_d;
      state_q       <= state_d;
    end
  end

  // Payload storage carries no reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= in_ray;
    end
  end

  assign prg_to_shader_stall = full_q;
  assign ray_valid           = valid_q;
  assign ray_data            = mem_q[rd_ptr_q];
  assign frame_done          = frame_done_q;
  assign frame_count         = frame_count_q;
  assign seq_error           = seq_error_q;
  assign err_pixelID         = err_id_q;

endmodule

// File: tb/tb_shader_ray_intake.sv
// Directed bench for shader_ray_intake: scoreboard queue of accepted rays plus a
// small reference model of occupancy, sequence error and frame counting.

module tb_shader_ray_intake;
  import shader_ray_pkg::*;

  localparam int NR    = 6;
  localparam int DEPTH = 4;
  localparam int W     = $bits(prg_ray_t);
  localparam pixelID_t LAST = pixelID_t'(NR - 1);

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      prg_valid = 1'b0;
  prg_ray_t  prg_data = '0;
  logic      stall_o;
  logic      ray_valid;
  logic [W-1:0] ray_data;
  logic      ray_stall = 1'b0;
  logic      frame_done;
  logic [7:0] frame_count;
  logic      seq_error;
  logic [15:0] err_pixelID;
  logic      clear_error = 1'b0;

  shader_ray_intake #(.NUM_RAYS(NR), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .prg_to_shader_valid(prg_valid), .prg_to_shader_data(prg_data),
    .prg_to_shader_stall(stall_o),
    .ray_valid(ray_valid), .ray_data(ray_data), .ray_stall(ray_stall),
    .frame_done(frame_done), .frame_count(frame_count),
    .seq_error(seq_error), .err_pixelID(err_pixelID), .clear_error(clear_error)
  );

  always #5 clk = ~clk;

  prg_ray_t sb[$];
  int       checks = 0;
  int       errors = 0;
  int       fd_count = 0;
  int       acc_count = 0;
  int       next_id = 0;
  bit       auto_id = 1'b1;
  bit       last_acc = 1'b0;
  logic [7:0] m_fc = 8'd0;
  bit       m_seq = 1'b0;
  pixelID_t m_err = '0;
  pixelID_t m_exp = '0;

  function automatic prg_ray_t mk_ray(input int id);
    prg_ray_t r;
    r.origin  = $urandom;
    r.dir     = $urandom;
    r.pixelID = pixelID_t'(id);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_ids(input int id);
    next_id  = id;
    prg_data = mk_ray(id);
  endtask

  // One clock: evaluate handshakes just before the edge, update the model, check after it.
  task automatic cycle();
    bit acc, pop, fd_exp;
    prg_ray_t exp_r;
    pixelID_t pid;
    @(negedge clk);
    acc = !rst && prg_valid && !stall_o;
    pop = !rst && ray_valid && !ray_stall;
    pid = prg_data.pixelID;
    if (pop) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL pop_underflow observed=%0d expected=nonzero", sb.size());
      end
      if (sb.size() != 0) begin
        exp_r = sb.pop_front();
        chk("ray_data", ray_data, exp_r);
      end
    end
    fd_exp = acc && (pid == LAST);
    if (acc) begin
      sb.push_back(prg_data);
      acc_count++;
      if ((pid != m_exp) && (!m_seq || clear_error)) begin
        m_seq = 1'b1;
        m_err = pid;
      end else if (clear_error) begin
        m_seq = 1'b0;
        m_err = '0;
      end
      m_exp = (pid == LAST) ? pixelID_t'(0) : pid + pixelID_t'(1);
      if (pid == LAST) m_fc = m_fc + 8'd1;
    end else if (clear_error) begin
      m_seq = 1'b0;
      m_err = '0;
    end
    if (rst) begin
      sb.delete();
      m_fc  = 8'd0;
      m_seq = 1'b0;
      m_err = '0;
      m_exp = '0;
    end
    @(posedge clk);
    #1;
    last_acc = acc;
    chk("frame_done", W'(frame_done), W'(fd_exp));
    if (frame_done) fd_count++;
    chk("ray_valid", W'(ray_valid), W'(sb.size() != 0));
    chk("stall", W'(stall_o), W'(sb.size() == DEPTH));
    chk("frame_count", W'(frame_count), W'(m_fc));
    chk("seq_error", W'(seq_error), W'(m_seq));
    chk("err_pixelID", W'(err_pixelID), W'(m_err));
    if (acc && auto_id) begin
      next_id  = (next_id == NR - 1) ? 0 : next_id + 1;
      prg_data = mk_ray(next_id);
    end
  endtask

  initial begin
    // Reset
    #1;
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_occupancy", W'(dut.count_q), W'(0));

    // One frame back-to-back with no downstream stall
    start_ids(0);
    prg_valid = 1'b1;
    for (int i = 0; i < NR; i++) cycle();
    prg_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("frame1_count", W'(frame_count), W'(8'd1));
    chk("frame1_pulses", W'(fd_count), W'(1));
    chk("frame1_seq", W'(seq_error), W'(1'b0));

    // Downstream stall: only DEPTH rays fit, then drain all six
    ray_stall = 1'b1;
    start_ids(0);
    prg_valid = 1'b1;
    acc_count = 0;
    for (int i = 0; i < 8; i++) cycle();
    chk("stall_accepts", W'(acc_count), W'(DEPTH));
    ray_stall = 1'b0;
    for (int i = 0; i < 40 && (acc_count < NR || sb.size() != 0); i++) begin
      if (acc_count >= NR) prg_valid = 1'b0;
      cycle();
    end
    prg_valid = 1'b0;
    chk("drain_accepts", W'(acc_count), W'(NR));
    chk("drain_empty", W'(sb.size()), W'(0));

    // Push and pop at full: push blocked; at occupancy 2 push+pop holds 2
    ray_stall = 1'b1;
    prg_valid = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    chk("full_occ", W'(dut.count_q), W'(DEPTH));
    ray_stall = 1'b0;
    chk("full_stall_seen", W'(stall_o), W'(1'b1));
    cycle();
    chk("full_no_push", W'(last_acc), W'(1'b0));
    chk("full_pop_occ", W'(dut.count_q), W'(DEPTH - 1));
    prg_valid = 1'b0;
    cycle();
    prg_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("pushpop_occ", W'(dut.count_q), W'(2));
    end
    prg_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // Reset mid-frame with three rays buffered
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    ray_stall = 1'b1;
    start_ids(0);
    prg_valid = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("pre_rst_occ", W'(dut.count_q), W'(3));
    ray_stall = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_mid_valid", W'(ray_valid), W'(1'b0));
    chk("rst_mid_occ", W'(dut.count_q), W'(0));
    start_ids(0);
    cycle();
    prg_valid = 1'b0;
    cycle();
    chk("rst_new_seq", W'(seq_error), W'(1'b0));

    // Sequence errors: IDs 0,1,3,4 then clear, then clear colliding with a mismatch
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    auto_id = 1'b0;
    prg_valid = 1'b1;
    prg_data = mk_ray(0); cycle();
    prg_data = mk_ray(1); cycle();
    prg_data = mk_ray(3); cycle();
    chk("err_set", W'(seq_error), W'(1'b1));
    chk("err_id3", W'(err_pixelID), W'(16'd3));
    prg_data = mk_ray(4); cycle();
    chk("err_keep", W'(err_pixelID), W'(16'd3));
    prg_valid = 1'b0;
    clear_error = 1'b1;
    cycle();
    clear_error = 1'b0;
    chk("err_clear", W'(seq_error), W'(1'b0));
    chk("err_id_clear", W'(err_pixelID), W'(16'd0));
    prg_valid = 1'b1;
    prg_data = mk_ray(2); cycle();
    prg_data = mk_ray(1);
    clear_error = 1'b1;
    cycle();
    clear_error = 1'b0;
    prg_valid = 1'b0;
    chk("err_clear_race", W'(seq_error), W'(1'b1));
    chk("err_clear_race_id", W'(err_pixelID), W'(16'd1));
    cycle();

    // 256 frames: frame_count wraps back to zero
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    auto_id = 1'b1;
    start_ids(0);
    fd_count = 0;
    acc_count = 0;
    prg_valid = 1'b1;
    for (int i = 0; i < 2000 && acc_count < 256 * NR; i++) cycle();
    prg_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("wrap_accepts", W'(acc_count), W'(256 * NR));
    chk("wrap_count", W'(frame_count), W'(8'd0));
    chk("wrap_pulses", W'(fd_count), W'(256));
    chk("wrap_seq", W'(seq_error), W'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shader_ray_intake.md
SHADER_RAY_INTAKE -- requirements
Module: shader_ray_intake

Interface
- REQ-001 The block SHALL have one clock and a synchronous, active-high reset: all state updates on the rising edge of clk, and rst is sampled only on that edge.
- REQ-002 Parameter NUM_RAYS, default `num_rays, SHALL be the number of rays per frame.
- REQ-003 Parameter DEPTH, default 8, SHALL be the internal FIFO depth, a power of two between 2 and 16.
- REQ-004 clk  input  1  system clock.
- REQ-005 rst  input  1  synchronous active-high reset.
- REQ-006 prg_to_shader_valid  input  1  upstream ray present.
- REQ-007 prg_to_shader_data  input  $bits(prg_ray_t)  ray from the generator: origin, dir, pixelID.
- REQ-008 prg_to_shader_stall  output  1  back-pressure to the generator.
- REQ-009 ray_valid  output  1  downstream ray present.
- REQ-010 ray_data  output  $bits(prg_ray_t)  head-of-FIFO ray.
- REQ-011 ray_stall  input  1  downstream back-pressure.
- REQ-012 frame_done  output  1  one-cycle pulse marking frame completion.
- REQ-013 frame_count  output  8  frames completed; wraps modulo 256.
- REQ-014 seq_error  output  1  sticky flag for an out-of-order pixelID.
- REQ-015 err_pixelID  output  $bits(pixelID_t)  pixelID of the first offending ray.
- REQ-016 clear_error  input  1  clears seq_error and err_pixelID.

Function
- REQ-017 An upstream accept SHALL occur in a cycle where prg_to_shader_valid=1 and prg_to_shader_stall=0; in that cycle the data is written into the FIFO.
- REQ-018 prg_to_shader_stall SHALL be driven directly from a register and SHALL equal 1 exactly when the FIFO occupancy equals DEPTH.
- REQ-019 A push SHALL NOT occur while the FIFO is full, even if a pop happens in the same cycle.
- REQ-020 The FIFO SHALL be first-word-fall-through: ray_valid = (occupancy != 0) and ray_data = oldest entry, both available with no read latency.
- REQ-021 A downstream pop SHALL occur when ray_valid=1 and ray_stall=0.
- REQ-022 ray_data and ray_valid SHALL hold steady while ray_stall=1.
- REQ-023 Latency SHALL be one cycle: a ray accepted into an empty FIFO at edge N appears with ray_valid=1 after edge N.
- REQ-024 When a push and a pop occur in the same cycle, occupancy SHALL be unchanged and data order preserved.
- REQ-025 The occupancy counter SHALL be $clog2(DEPTH+1) bits wide.
- REQ-026 The read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- REQ-027 Ray order SHALL be strict FIFO; payload bits SHALL pass through unaltered.
- REQ-028 An expected_id register SHALL track the next pixelID; on every accept its next value is 0 if the accepted pixelID equals NUM_RAYS-1, else accepted pixelID+1 (it resynchronises to the received ID).
- REQ-029 An accepted pixelID that differs from expected_id while seq_error=0 SHALL set seq_error and capture that pixelID in err_pixelID.
- REQ-030 Further mismatches while seq_error=1 SHALL NOT overwrite err_pixelID.
- REQ-031 clear_error=1 SHALL clear seq_error and err_pixelID to 0 on the next edge.
- REQ-032 If clear_error=1 in the same cycle as a mismatch, the mismatch SHALL win: seq_error=1 and err_pixelID=offending ID.
- REQ-033 An accept with pixelID=NUM_RAYS-1 SHALL pulse frame_done high for exactly the next cycle and increment frame_count, wrapping 255->0.
- REQ-034 This end-of-frame behaviour SHALL hold whether or not that ray was in sequence.
- REQ-035 Frame tracking SHALL be a two-state machine: INFRAME is entered from IDLE on any accept; INFRAME returns to IDLE on accepting pixelID=NUM_RAYS-1.
- REQ-036 An accept with pixelID=NUM_RAYS-1 while in IDLE SHALL still pulse frame_done and return to IDLE.

Reset
- REQ-037 While rst=1 at an edge, the block SHALL set: FIFO empty, pointers 0, ray_valid=0, prg_to_shader_stall=0, frame_done=0, frame_count=0, seq_error=0, err_pixelID=0, expected_id=0, state=IDLE.
- REQ-038 Reset asserted mid-frame SHALL discard all buffered rays, and no accept or pop SHALL occur in that cycle.
- REQ-039 ray_data content SHALL be don't-care while ray_valid=0.

Verification
- REQ-040 Bench SHALL run NUM_RAYS=6, DEPTH=4, ray_stall=0, pixelIDs 0..5 back-to-back -> six rays out in order, one cycle after each accept; frame_done pulses once in the cycle after ID 5 is accepted; frame_count=1; seq_error=0.
- REQ-041 Bench SHALL hold ray_stall=1 and offer 6 rays -> exactly 4 accepted; prg_to_shader_stall=1 from the cycle after the 4th accept; on releasing the stall, 6 rays drain in order.
- REQ-042 Bench SHALL apply continuous push and pop at occupancy 4 -> prg_to_shader_stall stays 1 and no push occurs; at occupancy 2, simultaneous push and pop -> occupancy stays 2.
- REQ-043 Bench SHALL send IDs 0,1,3,4 -> seq_error=1 and err_pixelID=3 after the ID-3 accept; ID 4 raises no new error; clear_error -> seq_error=0 and err_pixelID=0.
- REQ-044 Bench SHALL run 256 frames of 6 rays -> frame_count wraps to 0 and 256 frame_done pulses are counted.
- REQ-045 Bench SHALL assert rst with 3 rays buffered mid-frame -> ray_valid=0 and occupancy 0 next cycle; a new ID-0 ray is accepted without a seq_error.
